// File: rtl/udp_tx_packer.sv
// udp_tx_packer: buffers a valid/ready byte stream and hands it to the UDP stack as datagrams
// Ports: clk/resetn (async active-low); s_data/s_valid/s_last/s_ready input stream with flush marker;
// tx_start_en/tx_byte_num/tx_data/tx_req/tx_done stack user transmit port; busy (FSM not idle); level (FIFO occupancy).
module udp_tx_packer #(
  parameter int DEPTH_LOG2    = 11,
  parameter int MAX_PAYLOAD   = 1472,
  parameter int FLUSH_TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic                tx_start_en,
  output logic [15:0]         tx_byte_num,
  output logic [7:0]          tx_data,
  input  logic                tx_req,
  input  logic                tx_done,
  output logic                busy,
  output logic [DEPTH_LOG2:0] level
);
  localparam int AW = DEPTH_LOG2;
  localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(1 << AW);
  localparam logic [AW:0] MAX_L = (AW+1)'(MAX_PAYLOAD);
  localparam logic [CW-1:0] TO = CW'(FLUSH_TIMEOUT);
  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;
  state_t state;
  logic [7:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] len, sent, pop_n, level_next, launch_len;
  logic [CW-1:0] idle_cnt;
  logic flush_pend, wr_en, rd_en, abort, launch;
  assign s_ready = level != FULL && !flush_pend;
  assign wr_en = s_valid && s_ready;
  // tx_done during SEND abandons the datagram; its unsent bytes are dropped from the FIFO
  assign abort = state == SEND && tx_done;
  assign rd_en = state == SEND && !tx_done && tx_req && sent != len;
  assign pop_n = abort ? len - sent : (AW+1)'(rd_en);
  assign level_next = level + (AW+1)'(wr_en) - pop_n;
  assign launch_len = level >= MAX_L ? MAX_L : level;
  assign launch = state == IDLE && level != '0 && (level >= MAX_L || flush_pend || idle_cnt == TO);
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= s_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      flush_pend  <= 1'b0;
      idle_cnt    <= '0;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
      tx_data     <= '0;
      len         <= '0;
      sent        <= '0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(wr_en);
      rd_ptr      <= rd_ptr + pop_n[AW-1:0];
      level       <= level_next;
      flush_pend  <= (wr_en && s_last) || (flush_pend && level_next != '0);
      idle_cnt    <= (wr_en || launch || level == '0) ? '0 :
                     (state == IDLE && idle_cnt != TO) ? idle_cnt + CW'(1) : idle_cnt;
      tx_start_en <= launch;
      sent        <= launch ? '0 : sent + (AW+1)'(rd_en);
      if (rd_en) tx_data <= mem[rd_ptr];
      if (launch) begin
        len         <= launch_len;
        tx_byte_num <= 16'(launch_len);
      end
      unique case (state)
        IDLE:      state <= launch ? START : IDLE;
        START:     state <= SEND;
        SEND:      state <= tx_done ? IDLE : (sent == len ? WAIT_DONE : SEND);
        WAIT_DONE: state <= tx_done ? IDLE : WAIT_DONE;
      endcase
    end
endmodule

// File: tb/tb_udp_tx_packer.sv
// tb_udp_tx_packer: directed table plus corner sequences for udp_tx_packer (depth 32, payload 16, timeout 8)
module tb_udp_tx_packer;
  logic clk = 1'b0, resetn = 1'b0;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0, tx_req = 1'b0, tx_done = 1'b0;
  logic s_ready, tx_start_en, busy;
  logic [15:0] tx_byte_num;
  logic [7:0] tx_data;
  logic [5:0] level;
  udp_tx_packer #(.DEPTH_LOG2(5), .MAX_PAYLOAD(16), .FLUSH_TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_data(tx_data),
    .tx_req(tx_req), .tx_done(tx_done), .busy(busy), .level(level)
  );
  always #5 clk = ~clk;
  int cyc = 0, n_tests = 0, n_fail = 0;
  int n_start = 0, n_seen = 0, start_cyc = 0, start_len = 0, acc_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] next_byte = 8'h00, last_byte = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (tx_start_en) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
      start_len <= int'(tx_byte_num);
    end
  typedef struct {
    int n;
    bit last;
    int exp_len;
    int exp_lat;
    bit extra_req;
    bit exp_rdy;
  } vec_t;
  vec_t vecs[5];
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input bit last);
    int g = 0;
    s_data = next_byte; s_last = last; s_valid = 1'b1;
    while (!s_ready && g < 200) begin @(posedge clk); #1; g++; end
    check("push_ready", int'(s_ready), 1);
    @(posedge clk); #1;
    acc_cyc = cyc - 1;
    exp_q.push_back(next_byte);
    next_byte = next_byte + 8'd1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask
  task automatic wait_start(input int exp_len, input int exp_lat);
    int g = 0;
    while (n_start == n_seen && g < 300) begin @(negedge clk); #1; g++; end
    check("start_seen", int'(n_start != n_seen), 1);
    n_seen++;
    check("byte_num", start_len, exp_len);
    if (exp_lat >= 0) check("launch_lat", start_cyc - acc_cyc, exp_lat);
  endtask
  task automatic serve(input int n, input bit flat);
    logic [7:0] e;
    int lvl0;
    @(posedge clk); #1;
    tx_req = 1'b1;
    lvl0 = int'(level);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == n - 1) tx_req = 1'b0;
      e = 8'h00;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("tx_data", int'(tx_data), int'(e));
      if (flat) check("flat_level", int'(level), lvl0);
      last_byte = e;
    end
  endtask
  task automatic finish_dg(input int exp_len);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    check("busy_after_done", int'(busy), 0);
    check("byte_num_hold", int'(tx_byte_num), exp_len);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{n: 16, last: 1'b0, exp_len: 16, exp_lat: 2,  extra_req: 1'b0, exp_rdy: 1'b1};
    vecs[1] = '{n: 5,  last: 1'b1, exp_len: 5,  exp_lat: 2,  extra_req: 1'b1, exp_rdy: 1'b0};
    vecs[2] = '{n: 3,  last: 1'b0, exp_len: 3,  exp_lat: 10, extra_req: 1'b0, exp_rdy: 1'b1};
    vecs[3] = '{n: 1,  last: 1'b1, exp_len: 1,  exp_lat: 2,  extra_req: 1'b0, exp_rdy: 1'b0};
    vecs[4] = '{n: 7,  last: 1'b0, exp_len: 7,  exp_lat: 10, extra_req: 1'b1, exp_rdy: 1'b1};
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b1; #1;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_start_en", int'(tx_start_en), 0);
    check("rst_byte_num", int'(tx_byte_num), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(level), 0);
    @(posedge clk); #1;
    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) push(vecs[k].last && i == vecs[k].n - 1);
      check("ready_after_last", int'(s_ready), int'(vecs[k].exp_rdy));
      wait_start(vecs[k].exp_len, vecs[k].exp_lat);
      serve(vecs[k].exp_len, 1'b0);
      if (vecs[k].extra_req) begin
        tx_req = 1'b1;
        @(posedge clk); #1;
        tx_req = 1'b0;
        check("hold_data", int'(tx_data), int'(last_byte));
        check("hold_level", int'(level), 0);
      end
      finish_dg(vecs[k].exp_len);
      check("level_empty", int'(level), 0);
      check("ready_empty", int'(s_ready), 1);
    end
    // fill to full with the stack stalled, flush marker on the last byte, then drain as two datagrams
    for (int i = 0; i < 32; i++) push(i == 31);
    check("full_level", int'(level), 32);
    check("full_ready", int'(s_ready), 0);
    wait_start(16, -1);
    serve(16, 1'b0);
    finish_dg(16);
    check("split_ready_blocked", int'(s_ready), 0);
    wait_start(16, -1);
    serve(16, 1'b0);
    finish_dg(16);
    check("split_level", int'(level), 0);
    check("split_ready", int'(s_ready), 1);
    // one write per cycle while datagrams stream out
    for (int i = 0; i < 16; i++) push(1'b0);
    fork
      for (int i = 0; i < 48; i++) push(1'b0);
      for (int d = 0; d < 4; d++) begin
        wait_start(16, -1);
        serve(16, d < 2);
        finish_dg(16);
      end
    join
    check("conc_level", int'(level), 0);
    check("conc_queue", exp_q.size(), 0);
    // reset in the middle of a datagram
    for (int i = 0; i < 16; i++) push(1'b0);
    wait_start(16, 2);
    serve(7, 1'b0);
    resetn = 1'b0; #1;
    check("mid_rst_start_en", int'(tx_start_en), 0);
    check("mid_rst_byte_num", int'(tx_byte_num), 0);
    check("mid_rst_tx_data", int'(tx_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_ready", int'(s_ready), 1);
    exp_q.delete();
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(i == 3);
    wait_start(4, 2);
    serve(4, 1'b0);
    finish_dg(4);
    check("post_rst_level", int'(level), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
